dtc_cic_frame_aligner: RTL and testbench

Downstream consumer of the 84-bit front-end word bus that the DTC front-end emulator produces at 40 MHz. It locks onto the 8-word CIC stub-packet boundary by finding a fixed header byte, and tracks lock with a hit/miss state machine. It delivers framed 32-bit CIC_0 words with start/end markers, packet and header-error counters. Its outputs feed the DTC stub-processing logic.

---
 rtl/dtc_cic_frame_aligner.sv | 202 ++++++++++++++++++++
 tb/tb_dtc_cic_frame_aligner.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dtc_cic_frame_aligner.sv
// Locks onto the CIC_0 stub-packet boundary of the DTC front-end word bus and emits framed words.
// Optional CIC_1/CIC_0 comparison is built when CIC1_COMPARE_EN is defined.
module dtc_cic_frame_aligner #(
    parameter logic [7:0]  HEADER        = 8'hA5,
    parameter int unsigned PKT_WORDS     = 8,
    parameter int unsigned LOCK_THRESH   = 4,
    parameter int unsigned UNLOCK_THRESH = 2
) (
    input  logic                         CLK40,
    input  logic                         RESET,
    input  logic [83:0]                  DTC_FE_IN,
    output logic [31:0]                  PKT_DATA,
    output logic                         PKT_VALID,
    output logic                         PKT_SOP,
    output logic                         PKT_EOP,
    output logic [$clog2(PKT_WORDS)-1:0] WORD_IDX,
    output logic                         LOCKED,
    output logic [15:0]                  PKT_CNT,
    output logic [15:0]                  HDR_ERR_CNT,
    output logic                         CIC_MISMATCH
);

    localparam int unsigned IDX_W = $clog2(PKT_WORDS);
    localparam int unsigned THR_W = 4;

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   pos_q, pos_d;
    logic [THR_W-1:0]   hits_q, hits_d;
    logic [THR_W-1:0]   miss_q, miss_d;
    logic               acc_q, acc_d;
    logic [31:0]        s1_data_q;

    logic               hdr_hit_c;
    logic               slot0_c;
    logic               valid_c;
    logic               sop_c;
    logic               eop_c;
    logic               herr_c;
    logic [IDX_W-1:0]   idx_c;

    // Stage 1: capture the CIC_0 word
    always_ff @(posedge CLK40) begin
        if (RESET) begin
            s1_data_q <= '0;
        end else begin
            s1_data_q <= DTC_FE_IN[31:0];
        end
    end

    always_ff @(posedge CLK40) begin
        if (RESET) begin
            state_q <= S_SEARCH;
            pos_q   <= '0;
            hits_q  <= '0;
            miss_q  <= '0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            hits_q  <= hits_d;
            miss_q  <= miss_d;
            acc_q   <= acc_d;
        end
    end

    // Framing decisions on stage 1; acc tracks whether the current packet is being delivered
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q + IDX_W'(1);
        hits_d    = hits_q;
        miss_d    = miss_q;
        acc_d     = acc_q;
        valid_c   = 1'b0;
        herr_c    = 1'b0;
        idx_c     = pos_q;
        hdr_hit_c = (s1_data_q[31:24] == HEADER);
        slot0_c   = (pos_q == '0);

        case (state_q)
            S_SEARCH: begin
                pos_d = '0;
                idx_c = '0;
                acc_d = 1'b0;
                if (hdr_hit_c) begin
                    pos_d  = IDX_W'(1);
                    hits_d = THR_W'(1);
                    miss_d = '0;
                    if (LOCK_THRESH == 1) begin
                        state_d = S_LOCKED;
                        acc_d   = 1'b1;
                        valid_c = 1'b1;
                    end else begin
                        state_d = S_VERIFY;
                    end
                end
            end
            S_VERIFY: begin
                if (slot0_c) begin
                    if (hdr_hit_c) begin
                        hits_d = hits_q + THR_W'(1);
                        if (hits_q + THR_W'(1) == THR_W'(LOCK_THRESH)) begin
                            state_d = S_LOCKED;
                            acc_d   = 1'b1;
                            valid_c = 1'b1;
                        end
                    end else begin
                        state_d = S_SEARCH;
                        hits_d  = '0;
                        pos_d   = '0;
                    end
                end
            end
            S_LOCKED: begin
                if (slot0_c) begin
                    if (hdr_hit_c) begin
                        miss_d  = '0;
                        acc_d   = 1'b1;
                        valid_c = 1'b1;
                    end else begin
                        herr_c = 1'b1;
                        acc_d  = 1'b0;
                        miss_d = miss_q + THR_W'(1);
                        if (miss_q + THR_W'(1) == THR_W'(UNLOCK_THRESH)) begin
                            state_d = S_SEARCH;
                            hits_d  = '0;
                            miss_d  = '0;
                            pos_d   = '0;
                        end
                    end
                end else begin
                    valid_c = acc_q;
                end
            end
            default: begin
                state_d = S_SEARCH;
                pos_d   = '0;
                hits_d  = '0;
                miss_d  = '0;
                acc_d   = 1'b0;
            end
        endcase

        sop_c = valid_c && (idx_c == '0);
        eop_c = valid_c && (idx_c == IDX_W'(PKT_WORDS - 1));
    end

    // Stage 2: output registers; data/index are zeroed outside accepted packets
    always_ff @(posedge CLK40) begin
        if (RESET) begin
            PKT_DATA    <= '0;
            PKT_VALID   <= 1'b0;
            PKT_SOP     <= 1'b0;
            PKT_EOP     <= 1'b0;
            WORD_IDX    <= '0;
            LOCKED      <= 1'b0;
            PKT_CNT     <= '0;
            HDR_ERR_CNT <= '0;
        end else begin
            PKT_DATA  <= valid_c ? s1_data_q : 32'h0;
            PKT_VALID <= valid_c;
            PKT_SOP   <= sop_c;
            PKT_EOP   <= eop_c;
            WORD_IDX  <= valid_c ? idx_c : '0;
            LOCKED    <= (state_d == S_LOCKED);
            if (sop_c) begin
                PKT_CNT <= PKT_CNT + 16'd1;
            end
            if (herr_c && (HDR_ERR_CNT != 16'hFFFF)) begin
                HDR_ERR_CNT <= HDR_ERR_CNT + 16'd1;
            end
        end
    end

`ifdef CIC1_COMPARE_EN
    logic s1_mis_q;
    logic unused_bits_c;

    always_ff @(posedge CLK40) begin
        if (RESET) begin
            s1_mis_q     <= 1'b0;
            CIC_MISMATCH <= 1'b0;
        end else begin
            s1_mis_q     <= (DTC_FE_IN[71:40] != DTC_FE_IN[31:0]);
            CIC_MISMATCH <= valid_c & s1_mis_q;
        end
    end

    assign unused_bits_c = ^{DTC_FE_IN[83:72], DTC_FE_IN[39:32]};
`else
    logic unused_bits_c;

    assign CIC_MISMATCH  = 1'b0;
    assign unused_bits_c = ^{DTC_FE_IN[83:40], DTC_FE_IN[39:32]};
`endif

endmodule

// File: tb/tb_dtc_cic_frame_aligner.sv
// Directed bench for dtc_cic_frame_aligner: reset, false header, lock, header loss, CIC_1 compare, mid-packet reset.
module tb_dtc_cic_frame_aligner;

    logic        CLK40 = 1'b0;
    logic        RESET;
    logic [83:0] DTC_FE_IN;
    logic [31:0] PKT_DATA;
    logic        PKT_VALID;
    logic        PKT_SOP;
    logic        PKT_EOP;
    logic [2:0]  WORD_IDX;
    logic        LOCKED;
    logic [15:0] PKT_CNT;
    logic [15:0] HDR_ERR_CNT;
    logic        CIC_MISMATCH;

    dtc_cic_frame_aligner dut (
        .CLK40       (CLK40),
        .RESET       (RESET),
        .DTC_FE_IN   (DTC_FE_IN),
        .PKT_DATA    (PKT_DATA),
        .PKT_VALID   (PKT_VALID),
        .PKT_SOP     (PKT_SOP),
        .PKT_EOP     (PKT_EOP),
        .WORD_IDX    (WORD_IDX),
        .LOCKED      (LOCKED),
        .PKT_CNT     (PKT_CNT),
        .HDR_ERR_CNT (HDR_ERR_CNT),
        .CIC_MISMATCH(CIC_MISMATCH)
    );

    always #5 CLK40 = ~CLK40;

    typedef struct packed {
        logic        v;
        logic        s;
        logic        e;
        logic [2:0]  idx;
        logic [31:0] d;
        logic        l;
        logic [15:0] pc;
        logic [15:0] he;
        logic        m;
    } exp_t;

    int    total = 0;
    int    bad   = 0;
    exp_t  pend;
    string pend_name;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input exp_t e, input string where);
        chk({where, ".valid"},  32'(PKT_VALID),    32'(e.v));
        chk({where, ".sop"},    32'(PKT_SOP),      32'(e.s));
        chk({where, ".eop"},    32'(PKT_EOP),      32'(e.e));
        chk({where, ".idx"},    32'(WORD_IDX),     32'(e.idx));
        chk({where, ".data"},   PKT_DATA,          e.d);
        chk({where, ".locked"}, 32'(LOCKED),       32'(e.l));
        chk({where, ".pktcnt"}, 32'(PKT_CNT),      32'(e.pc));
        chk({where, ".hdrerr"}, 32'(HDR_ERR_CNT),  32'(e.he));
        chk({where, ".mis"},    32'(CIC_MISMATCH), 32'(e.m));
    endtask

    // Outputs seen after an edge belong to the word driven one step earlier
    task automatic step(input logic [83:0] w, input logic rst, input exp_t e, input string name);
        DTC_FE_IN = w;
        RESET     = rst;
        @(posedge CLK40);
        #1;
        if (rst) check_out('0, {name, "(rst)"});
        else     check_out(pend, pend_name);
        pend      = rst ? '0 : e;
        pend_name = name;
    endtask

    function automatic logic [83:0] mkw(input bit hdr, input int tag, input int k, input bit flip);
        logic [31:0] c0;
        logic [31:0] c1;
        c0 = {hdr ? 8'hA5 : 8'h3C, 24'(tag * 16 + k)};
        c1 = c0;
        if (flip) c1[5] = ~c1[5];
        return {12'h0, c1, 8'h0, c0};
    endfunction

    function automatic logic [83:0] rand_word();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        r[31:24] = 8'h3C;
        return r[83:0];
    endfunction

    task automatic idle(input int n, input bit lk, input int pc, input int he);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e    = '0;
            e.l  = lk;
            e.pc = 16'(pc);
            e.he = 16'(he);
            step(mkw(1'b0, 255, i, 1'b0), 1'b0, e, $sformatf("idle%0d", i));
        end
    endtask

    // One 8-word packet; rst_at < 8 asserts RESET while that word is input
    task automatic send_pkt(input bit hdr, input int tag, input bit acc, input bit lk,
                            input int pc, input int he, input bit flip, input int rst_at);
        exp_t        e;
        logic [83:0] w;
        for (int k = 0; k < 8; k++) begin
            w = mkw(hdr && (k == 0), tag, k, flip && (k == 3));
            e = '0;
            if (k < rst_at) begin
                e.v   = acc;
                e.s   = acc && (k == 0);
                e.e   = acc && (k == 7);
                e.idx = acc ? 3'(k) : 3'd0;
                e.d   = acc ? w[31:0] : 32'h0;
                e.l   = lk;
                e.pc  = 16'(pc);
                e.he  = 16'(he);
`ifdef CIC1_COMPARE_EN
                e.m   = acc && flip && (k == 3);
`else
                e.m   = 1'b0;
`endif
            end
            step(w, (k == rst_at), e, $sformatf("p%0d.w%0d", tag, k));
        end
    endtask

    initial begin
        RESET     = 1'b1;
        DTC_FE_IN = '0;
        pend      = '0;
        pend_name = "init";

        // Reset held with random input, then one cycle after release
        for (int i = 0; i < 3; i++) step(rand_word(), 1'b1, '0, $sformatf("reset%0d", i));
        step(rand_word(), 1'b0, '0, "release");
        idle(3, 1'b0, 0, 0);

        // Lone header followed by a missing one: back to SEARCH, nothing output
        send_pkt(1'b1, 1, 1'b0, 1'b0, 0, 0, 1'b0, 8);
        send_pkt(1'b0, 2, 1'b0, 1'b0, 0, 0, 1'b0, 8);
        idle(2, 1'b0, 0, 0);

        // Lock on the 4th header; that packet is delivered
        send_pkt(1'b1, 3, 1'b0, 1'b0, 0, 0, 1'b0, 8);
        send_pkt(1'b1, 4, 1'b0, 1'b0, 0, 0, 1'b0, 8);
        send_pkt(1'b1, 5, 1'b0, 1'b0, 0, 0, 1'b0, 8);
        send_pkt(1'b1, 6, 1'b1, 1'b1, 1, 0, 1'b0, 8);
        send_pkt(1'b1, 7, 1'b1, 1'b1, 2, 0, 1'b0, 8);

        // CIC_1 bit 45 flipped on word 3
        send_pkt(1'b1, 8, 1'b1, 1'b1, 3, 0, 1'b1, 8);

        // Single header loss: packet dropped, lock held
        send_pkt(1'b0, 9, 1'b0, 1'b1, 3, 1, 1'b0, 8);
        send_pkt(1'b1, 10, 1'b1, 1'b1, 4, 1, 1'b0, 8);

        // Reset at word 5 of a locked packet
        send_pkt(1'b1, 11, 1'b1, 1'b1, 5, 1, 1'b0, 5);

        // Relock needs four fresh headers; counters restart
        send_pkt(1'b1, 12, 1'b0, 1'b0, 0, 0, 1'b0, 8);
        send_pkt(1'b1, 13, 1'b0, 1'b0, 0, 0, 1'b0, 8);
        send_pkt(1'b1, 14, 1'b0, 1'b0, 0, 0, 1'b0, 8);
        send_pkt(1'b1, 15, 1'b1, 1'b1, 1, 0, 1'b0, 8);

        // Two consecutive missing headers: lock lost at the second slot
        send_pkt(1'b0, 16, 1'b0, 1'b1, 1, 1, 1'b0, 8);
        send_pkt(1'b0, 17, 1'b0, 1'b0, 1, 2, 1'b0, 8);
        send_pkt(1'b1, 18, 1'b0, 1'b0, 1, 2, 1'b0, 8);
        idle(1, 1'b0, 1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
